wait_time_display_mux: RTL and testbench
========================================

Name: wait_time_display_mux

Overview:
- Parametrised multi-digit wait-time display driver for the queue monitor.
- Accepts an unsigned binary wait time and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed, common-anode 7-segment array, with leading-zero blanking and overflow indication.
- Every input value 0..10^DIGITS-1 is decoded exactly; there are no unmapped values.

Parameters:
BIN_W, 8, width of binary input; legal range 4..16.
DIGITS, 3, number of displayed decimal digits; legal range 1..5.
REFRESH_DIV, 50000, clk cycles each digit stays selected; must be >= 2.
LZB, 1, 1 = blank leading zeros (digit 0 is always shown); 0 = show all zeros.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
bin_in  in  BIN_W  unsigned wait time; sampled only on an accepted load.
load  in  1  request conversion of bin_in.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse when the new value is committed to the display.
ovf  out  1  committed value exceeds 10^DIGITS-1.
seg  out  7  segments {a,b,c,d,e,f,g}, active-low (0 = lit).
an  out  DIGITS  digit enables, active-low, one-hot-low; an[0] = least significant digit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - seg=7'b1111111, an=all 1, busy=0, done=0, ovf=0.
  - Committed BCD register = 0; FSM=IDLE; refresh counter=0; scan index=0.
- After reset release, the display shows "0" (digit 0 lit, others blank if LZB=1).
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - load=1 at edge T captures bin_in and sets ovf_pending = (bin_in > 10^DIGITS-1).
  - Clears the BCD scratch register and the step counter; enters SHIFT; busy=1 after edge T.
- SHIFT:
  - On each of edges T+1..T+BIN_W: add 3 to every scratch nibble >= 5, then shift left by 1, taking the binary MSB in.
  - Scratch width is 4*DIGITS + 4 (one guard nibble).
  - After BIN_W steps, go to COMMIT.
- COMMIT, at edge T+BIN_W+1:
  - Committed BCD <= low 4*DIGITS bits of scratch; ovf <= ovf_pending.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
  - Total latency from load edge to done is BIN_W+1 cycles.
- load while busy=1 is ignored; no queueing. load held high in IDLE restarts a conversion each time the FSM returns to IDLE.
- The committed value changes only at COMMIT, so the display never shows a partial conversion.
- Scan path (independent of the FSM, runs continuously after reset):
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On wrap: scan index advances, wrapping from DIGITS-1 to 0; outputs update the same edge.
  - seg and an are registered: at most one an bit is low; during reset none are low.
- Digit codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111, dash=1111110.
  - Nibble values >9 cannot occur; if they do, drive blank.
- Leading-zero blanking (LZB=1): digit i>0 is blank if it and all higher digits are 0.
- Overflow: while ovf=1, every digit shows dash and an still scans.
- Reset mid-conversion aborts: committed value returns to 0, and no done pulse is produced.

Test Plan (BIN_W=8, DIGITS=3, REFRESH_DIV=4, LZB=1 unless stated):
- Reset, then release:
  - seg=1111111 and an=111 during reset.
  - After the first refresh wrap, an=110 and seg=0000001; an[2:1] positions show blank.
- load with bin_in=21:
  - busy high for 8 cycles; done pulses exactly 9 cycles after the load edge.
  - Scan shows units 1001111, tens 0010010, hundreds 1111111.
- load 255: digits 0100100 / 0100100 / 0010010 (units/tens/hundreds); ovf=0. Then load 100: tens shows 0000001 (not blanked), hundreds 1001111.
- DIGITS=2, load 150:
  - ovf=1; both digits show 1111110.
  - A following load 9 clears ovf; units 0000100, tens blank.
- load 21, then load 99 on the 3rd busy cycle: the second load is ignored; committed value 21; only one done pulse.
- load 200, then assert rst_n=0 on the 4th SHIFT cycle:
  - Outputs reach reset values immediately; no done pulse.
  - After release, the display shows "0".

Source files
------------

// File: rtl/wait_time_display_mux.sv
// Wait-time display driver: binary to BCD via shift-add-3,
// multiplexed common-anode 7-segment scan with blanking/overflow.
module wait_time_display_mux #(
    parameter int BIN_W       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int LZB         = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BW  = 4 * DIGITS;
    localparam int SW  = BW + 4;
    localparam int CW  = $clog2(REFRESH_DIV);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STW = $clog2(BIN_W + 1);
    localparam int unsigned MAXV = 10 ** DIGITS - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t           state, state_n;
    logic [BIN_W-1:0] bin_q;
    logic [SW-1:0]    scr, scr_adj;
    logic [STW-1:0]   step;
    logic             ovf_pend;
    logic [BW-1:0]    bcd;

    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [3:0]       nib;
    logic             lz;
    logic [6:0]       seg_n;
    logic [DIGITS-1:0] an_n;

    assign busy = (state == SHIFT);

    always_comb begin
        scr_adj = scr;
        for (int i = 0; i <= DIGITS; i++) begin
            if (scr[4*i +: 4] >= 4'd5)
                scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (load) state_n = SHIFT;
            SHIFT:   if (step == STW'(BIN_W - 1)) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            scr      <= '0;
            step     <= '0;
            ovf_pend <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_q    <= bin_in;
                        scr      <= '0;
                        step     <= '0;
                        ovf_pend <= 32'(bin_in) > MAXV;
                    end
                end
                SHIFT: begin
                    scr   <= SW'({scr_adj, bin_q[BIN_W-1]});
                    bin_q <= bin_q << 1;
                    step  <= step + 1'b1;
                end
                COMMIT: begin
                    bcd  <= scr[BW-1:0];
                    ovf  <= ovf_pend;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Digit shown at a wrap is the current index; index then advances.
    always_comb begin
        nib  = 4'd0;
        lz   = 1'b0;
        an_n = ~(DIGITS'(1) << idx);
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                nib = bcd[4*i +: 4];
                lz  = (LZB != 0) && (i > 0) && ((bcd >> (4*i)) == '0);
            end
        end
        case (nib)
            4'd0:    seg_n = 7'b0000001;
            4'd1:    seg_n = 7'b1001111;
            4'd2:    seg_n = 7'b0010010;
            4'd3:    seg_n = 7'b0000110;
            4'd4:    seg_n = 7'b1001100;
            4'd5:    seg_n = 7'b0100100;
            4'd6:    seg_n = 7'b0100000;
            4'd7:    seg_n = 7'b0001111;
            4'd8:    seg_n = 7'b0000000;
            4'd9:    seg_n = 7'b0000100;
            default: seg_n = 7'b1111111;
        endcase
        if (lz)
            seg_n = 7'b1111111;
        if (ovf)
            seg_n = 7'b1111110;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
            seg <= 7'b1111111;
            an  <= '1;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            seg <= seg_n;
            an  <= an_n;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wait_time_display_mux.sv
// Directed bench for wait_time_display_mux: 3-digit and 2-digit
// instances with a fast refresh divider.
module tb_wait_time_display_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bin3, bin2;
    logic       ld3, ld2;
    logic       busy3, done3, ovf3, busy2, done2, ovf2;
    logic [6:0] seg3, seg2;
    logic [2:0] an3;
    logic [1:0] an2;

    int n_chk = 0;
    int n_fail = 0;
    int bn, dk, dn;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] DSH = 7'b1111110;

    always #5 clk = ~clk;

    wait_time_display_mux #(.BIN_W(8), .DIGITS(3), .REFRESH_DIV(4), .LZB(1)) u3 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin3), .load(ld3),
        .busy(busy3), .done(done3), .ovf(ovf3), .seg(seg3), .an(an3)
    );

    wait_time_display_mux #(.BIN_W(8), .DIGITS(2), .REFRESH_DIV(4), .LZB(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin2), .load(ld2),
        .busy(busy2), .done(done2), .ovf(ovf2), .seg(seg2), .an(an2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic scan(input bit two, input int d, input logic [6:0] exp,
                        input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (two) hit = (an2 == ~(2'(1) << d));
            else     hit = (an3 == ~(3'(1) << d));
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
        else      chk(tag, two ? int'(seg2) : int'(seg3), int'(exp));
    endtask

    task automatic conv(input bit two, input logic [7:0] v,
                        output int busy_n, output int done_k,
                        output int done_n);
        @(negedge clk);
        if (two) begin bin2 = v; ld2 = 1'b1; end
        else     begin bin3 = v; ld3 = 1'b1; end
        @(posedge clk);
        busy_n = 0; done_k = -1; done_n = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ld2 = 1'b0; ld3 = 1'b0;
            if (two ? busy2 : busy3) busy_n++;
            if (two ? done2 : done3) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ld3 = 1'b0; ld2 = 1'b0; bin3 = '0; bin2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg3, BLK);
        chk("rst_an", an3, 3'b111);
        chk("rst_busy", busy3, 0);
        chk("rst_done", done3, 0);
        chk("rst_ovf", ovf3, 0);

        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 10 && an3 == 3'b111; k++) @(negedge clk);
        chk("first_an", an3, 3'b110);
        chk("first_seg", seg3, 7'b0000001);
        scan(0, 1, BLK, "zero_d1");
        scan(0, 2, BLK, "zero_d2");

        conv(0, 8'd21, bn, dk, dn);
        chk("c21_busy", bn, 8);
        chk("c21_done_at", dk, 9);
        chk("c21_done_n", dn, 1);
        scan(0, 0, 7'b1001111, "c21_d0");
        scan(0, 1, 7'b0010010, "c21_d1");
        scan(0, 2, BLK, "c21_d2");

        conv(0, 8'd255, bn, dk, dn);
        chk("c255_ovf", ovf3, 0);
        scan(0, 0, 7'b0100100, "c255_d0");
        scan(0, 1, 7'b0100100, "c255_d1");
        scan(0, 2, 7'b0010010, "c255_d2");

        conv(0, 8'd100, bn, dk, dn);
        scan(0, 0, 7'b0000001, "c100_d0");
        scan(0, 1, 7'b0000001, "c100_d1");
        scan(0, 2, 7'b1001111, "c100_d2");

        conv(1, 8'd150, bn, dk, dn);
        chk("c150_done_n", dn, 1);
        chk("c150_ovf", ovf2, 1);
        scan(1, 0, DSH, "c150_d0");
        scan(1, 1, DSH, "c150_d1");
        conv(1, 8'd9, bn, dk, dn);
        chk("c9_ovf", ovf2, 0);
        scan(1, 0, 7'b0000100, "c9_d0");
        scan(1, 1, BLK, "c9_d1");

        @(negedge clk); bin3 = 8'd21; ld3 = 1'b1;
        @(posedge clk);
        dn = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) ld3 = 1'b0;
            if (k == 2) begin bin3 = 8'd99; ld3 = 1'b1; end
            if (k == 3) ld3 = 1'b0;
            if (done3) dn++;
        end
        chk("ign_done_n", dn, 1);
        scan(0, 0, 7'b1001111, "ign_d0");
        scan(0, 1, 7'b0010010, "ign_d1");
        scan(0, 2, BLK, "ign_d2");

        @(negedge clk); bin3 = 8'd200; ld3 = 1'b1;
        @(posedge clk);
        @(negedge clk) ld3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", busy3, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_seg", seg3, BLK);
        chk("abort_an", an3, 3'b111);
        chk("abort_busy", busy3, 0);
        chk("abort_done", done3, 0);
        chk("abort_ovf", ovf3, 0);
        dn = 0;
        repeat (3) begin @(negedge clk); if (done3) dn++; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done3) dn++; end
        chk("abort_no_done", dn, 0);
        scan(0, 0, 7'b0000001, "abort_d0");
        scan(0, 1, BLK, "abort_d1");
        scan(0, 2, BLK, "abort_d2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
